// File: rtl/montre_de1_cpu_debug_mem_access.sv
// JTAG/CPU shared access to the on-chip debug RAM.
// Ports: jdo + OCI-mem strobes in; MonDReg/monitor_ready/monitor_error out;
//        avs_* slave port for the debug monitor. JTAG beats the CPU port.
module montre_de1_cpu_debug_mem_access #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAP, WR} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wr_data;
    logic              ack_pend;
    logic              any_act;
    logic              accept;
    logic              cpu_wr;
    logic              cpu_rd;

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_rd;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;

    logic              unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    assign any_act = take_action_ocimem_a | take_action_ocimem_b
                   | take_no_action_ocimem_a;
    assign accept  = any_act && (state == IDLE);

    assign avs_waitrequest = (state != IDLE) || any_act;
    // Write wins when read and write are both raised.
    assign cpu_wr = avs_write && !avs_waitrequest;
    assign cpu_rd = avs_read && !avs_write && !avs_waitrequest;
    assign avs_readdata = ram_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (take_action_ocimem_a)
                    state_nx = jdo[35] ? RD_ISSUE : IDLE;
                else if (take_action_ocimem_b)
                    state_nx = WR;
                else if (take_no_action_ocimem_a)
                    state_nx = RD_ISSUE;
            end
            RD_ISSUE: state_nx = RD_CAP;
            RD_CAP:   state_nx = IDLE;
            WR:       state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // RAM port steering: JTAG phases own it outside IDLE, CPU inside.
    always_comb begin
        ram_addr  = addr;
        ram_we    = 1'b0;
        ram_rd    = 1'b0;
        ram_be    = 4'hf;
        ram_wdata = wr_data;
        unique case (state)
            RD_ISSUE: ram_rd = 1'b1;
            WR:       ram_we = 1'b1;
            IDLE: begin
                if (cpu_wr) begin
                    ram_we    = 1'b1;
                    ram_addr  = avs_address;
                    ram_be    = avs_byteenable;
                    ram_wdata = avs_writedata;
                end else if (cpu_rd) begin
                    ram_rd   = 1'b1;
                    ram_addr = avs_address;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr              <= '0;
            wr_data           <= '0;
            MonDReg           <= '0;
            monitor_ready     <= 1'b0;
            monitor_error     <= 1'b0;
            avs_readdatavalid <= 1'b0;
            ack_pend          <= 1'b0;
        end else begin
            avs_readdatavalid <= cpu_rd;
            ack_pend          <= 1'b0;
            if (any_act && state != IDLE)
                monitor_error <= 1'b1;
            if (accept) begin
                monitor_ready <= 1'b0;
                if (take_action_ocimem_a) begin
                    addr     <= jdo[ADDR_W+1:2];
                    ack_pend <= !jdo[35];
                    if (jdo[34])
                        monitor_error <= 1'b0;
                end else if (take_action_ocimem_b) begin
                    wr_data <= jdo[34:3];
                end
            end else if (ack_pend) begin
                monitor_ready <= 1'b1;
            end
            if (state == RD_CAP) begin
                MonDReg       <= ram_q;
                addr          <= addr + 1'b1;
                monitor_ready <= 1'b1;
            end
            if (state == WR) begin
                addr          <= addr + 1'b1;
                monitor_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (ram_be[i])
                    mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        if (ram_rd)
            ram_q <= mem[ram_addr];
    end

endmodule

// File: tb/tb_montre_de1_cpu_debug_mem_access.sv
// Directed bench for montre_de1_cpu_debug_mem_access.
// Hand-computed expectations for JTAG/CPU access to the debug RAM.
module tb_montre_de1_cpu_debug_mem_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;

    int total = 0;
    int bad   = 0;

    montre_de1_cpu_debug_mem_access #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_readdatavalid       (avs_readdatavalid),
        .avs_waitrequest         (avs_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        cyc();
        avs_write      = 1'b0;
    endtask

    task automatic jtag_a(input logic [7:0] a, input logic rd,
                          input logic clr);
        jdo       = '0;
        jdo[35]   = rd;
        jdo[34]   = clr;
        jdo[9:2]  = a;
        take_action_ocimem_a = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo       = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        cyc();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jtag_n();
        take_no_action_ocimem_a = 1'b1;
        cyc();
        take_no_action_ocimem_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        cyc();
        cyc();
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'h0);
        chk("rst_error", {31'b0, monitor_error}, 32'h0);
        chk("rst_rdv", {31'b0, avs_readdatavalid}, 32'h0);
        chk("rst_wait", {31'b0, avs_waitrequest}, 32'h0);
        #3 reset_n = 1'b1;
        cyc();

        // Seed RAM through the CPU port.
        cpu_write(8'h05, 32'hDEADBEEF, 4'hf);
        cpu_write(8'h00, 32'h0BADF00D, 4'hf);
        cpu_write(8'h21, 32'h33333333, 4'hf);

        // JTAG read of 0x05: ready after three edges.
        jtag_a(8'h05, 1'b1, 1'b0);
        chk("rd_ready_t0", {31'b0, monitor_ready}, 32'h0);
        cyc();
        chk("rd_ready_t1", {31'b0, monitor_ready}, 32'h0);
        cyc();
        chk("rd_ready_t2", {31'b0, monitor_ready}, 32'h1);
        chk("rd_data", MonDReg, 32'hDEADBEEF);
        chk("rd_addr", {24'b0, dut.addr}, 32'h06);

        // Address-only load, then write at 0xFF, wrap to 0.
        jtag_a(8'hFF, 1'b0, 1'b0);
        chk("ld_ready_t0", {31'b0, monitor_ready}, 32'h0);
        cyc();
        chk("ld_ready_t1", {31'b0, monitor_ready}, 32'h1);
        chk("ld_addr", {24'b0, dut.addr}, 32'hFF);
        jtag_b(32'h12345678);
        chk("wr_ready_t0", {31'b0, monitor_ready}, 32'h0);
        cyc();
        chk("wr_ready_t1", {31'b0, monitor_ready}, 32'h1);
        chk("wr_wrap", {24'b0, dut.addr}, 32'h00);
        jtag_n();
        cyc();
        cyc();
        chk("wrap_rd", MonDReg, 32'h0BADF00D);
        jtag_a(8'hFF, 1'b1, 1'b0);
        cyc();
        cyc();
        chk("wr_readback", MonDReg, 32'h12345678);

        // Strobe while busy is dropped and sets the sticky error.
        jtag_a(8'h20, 1'b0, 1'b0);
        cyc();
        jtag_b(32'h11111111);
        jtag_b(32'h22222222);
        chk("drop_error", {31'b0, monitor_error}, 32'h1);
        chk("drop_addr", {24'b0, dut.addr}, 32'h21);
        jtag_n();
        cyc();
        cyc();
        chk("drop_ram", MonDReg, 32'h33333333);
        chk("err_sticky", {31'b0, monitor_error}, 32'h1);
        jtag_a(8'h20, 1'b1, 1'b1);
        chk("err_clear", {31'b0, monitor_error}, 32'h0);
        cyc();
        cyc();
        chk("first_wr", MonDReg, 32'h11111111);

        // CPU byte-enabled write and read.
        cpu_write(8'h10, 32'h0, 4'hf);
        cpu_write(8'h10, 32'hAABBCCDD, 4'b0011);
        avs_address = 8'h10;
        avs_read    = 1'b1;
        chk("cpu_wait0", {31'b0, avs_waitrequest}, 32'h0);
        cyc();
        avs_read = 1'b0;
        chk("cpu_rdv", {31'b0, avs_readdatavalid}, 32'h1);
        chk("cpu_data", avs_readdata, 32'h0000CCDD);
        cyc();
        chk("cpu_rdv_off", {31'b0, avs_readdatavalid}, 32'h0);

        // CPU read collides with a JTAG read: JTAG first.
        avs_read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        #1;
        chk("coll_wait0", {31'b0, avs_waitrequest}, 32'h1);
        cyc();
        take_no_action_ocimem_a = 1'b0;
        chk("coll_wait1", {31'b0, avs_waitrequest}, 32'h1);
        chk("coll_rdv1", {31'b0, avs_readdatavalid}, 32'h0);
        cyc();
        chk("coll_wait2", {31'b0, avs_waitrequest}, 32'h1);
        cyc();
        chk("coll_wait3", {31'b0, avs_waitrequest}, 32'h0);
        chk("coll_jtag", MonDReg, 32'h33333333);
        cyc();
        avs_read = 1'b0;
        chk("coll_rdv", {31'b0, avs_readdatavalid}, 32'h1);
        chk("coll_data", avs_readdata, 32'h0000CCDD);

        // Reset in RD_CAP, with the error flag set beforehand.
        jtag_a(8'h05, 1'b1, 1'b0);
        jtag_n();
        chk("pre_rst_err", {31'b0, monitor_error}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_mondreg", MonDReg, 32'h0);
        chk("mid_rst_ready", {31'b0, monitor_ready}, 32'h0);
        chk("mid_rst_error", {31'b0, monitor_error}, 32'h0);
        chk("mid_rst_addr", {24'b0, dut.addr}, 32'h0);
        chk("mid_rst_wait", {31'b0, avs_waitrequest}, 32'h0);
        #2 reset_n = 1'b1;
        cyc();
        jtag_n();
        cyc();
        cyc();
        chk("post_rst_rd", MonDReg, 32'h0BADF00D);
        chk("post_rst_rdy", {31'b0, monitor_ready}, 32'h1);
        chk("post_rst_addr", {24'b0, dut.addr}, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
